lane_hit_judge: RTL and testbench
=================================

Name: lane_hit_judge

Overview:
- Consumer side of one falling-block lane: watches the lane's block_h stream and the player's key for that lane.
- Judges each spawned block once: perfect, hit or miss. Flags stray presses.
- Maintains lane score, combo and max combo for the scoreboard/7-seg path.
- One instance per lane, clocked by the same beat-tenth clock that advances block_h.

Parameters:
- JUDGE_LO, 560: lowest block_h (inclusive) accepted as a hit.
- JUDGE_HI, 680: highest block_h (inclusive) accepted as a hit. A block beyond this is a miss.
- PERF_LO, 600: lowest block_h (inclusive) of the perfect sub-window.
- PERF_HI, 640: highest block_h (inclusive) of the perfect sub-window.
- BOTTOM, 720: parked/off-screen block_h value.
- HIT_PTS, 1: points added for a hit.
- PERF_PTS, 2: points added for a perfect.
- SCORE_MAX, 999: score saturation value.

Ports:
- clk  in  1  lane clock (clk_beat_ten domain)
- rst_n  in  1  asynchronous active-low reset
- restart  in  1  synchronous clear to reset state, sampled on the clk rising edge
- stop_or_endgame  in  1  freeze: keys ignored, state and counters held
- key  in  1  lane key level, already synchronized/debounced upstream
- block_h  in  10  lane block vertical position from the lane block generator
- hit_pulse  out  1  one-cycle pulse: block hit (asserted for perfect too)
- perfect_pulse  out  1  one-cycle pulse: hit inside the perfect window
- miss_pulse  out  1  one-cycle pulse: block lost
- stray_pulse  out  1  one-cycle pulse: key press with nothing judgeable
- score  out  10  accumulated points, saturating at SCORE_MAX
- combo  out  7  consecutive hits, saturating at 127
- max_combo  out  7  highest combo since reset/restart
- judge_state  out  2  encoding: 0 IDLE, 1 ACTIVE, 2 JUDGED

Behaviour:
- Reset (rst_n=0) and restart:
  - state IDLE; all pulses 0; score, combo and max_combo 0.
  - prev_block_h = BOTTOM; key_prev = 0.
- Internal registers: key_prev and prev_block_h, updated every non-frozen cycle.
- Derived conditions:
  - key_edge = key & ~key_prev.
  - respawn = block_h < prev_block_h.
  - in_win = JUDGE_LO <= block_h <= JUDGE_HI.
  - in_perf = PERF_LO <= block_h <= PERF_HI.
- All outputs are registered. A judgement pulse appears on the edge that samples its condition and lasts exactly one cycle.
- Freeze (stop_or_endgame=1):
  - no state, counter or prev-register updates; pulses 0.
  - A key held through an unfreeze does not create an edge, because key_prev is held.
- FSM, evaluated per cycle in this priority order:
  - IDLE:
    - respawn -> ACTIVE.
    - key_edge (no respawn) -> stray.
  - ACTIVE:
    - respawn -> miss for the abandoned block; stay ACTIVE for the new block.
    - key_edge & in_win -> hit (plus perfect if in_perf); go JUDGED.
    - block_h > JUDGE_HI -> miss; go JUDGED. A key_edge in the same cycle raises no stray.
    - key_edge & block_h < JUDGE_LO -> stray; stay ACTIVE; block stays judgeable.
  - JUDGED:
    - respawn -> ACTIVE.
    - block_h == BOTTOM -> IDLE.
    - key_edge -> stray.
- Respawn in the same cycle as key_edge: the key is judged against the new block_h. With a normal spawn height of 120 this gives a stray.
- Scoring:
  - hit: score += HIT_PTS; perfect: score += PERF_PTS instead.
  - Add in 11 bits, then clamp to SCORE_MAX.
- Combo:
  - hit: combo + 1, saturating at 127.
  - miss or stray: combo = 0.
  - max_combo updates to the new combo value in the same cycle the combo exceeds it.
- Pulse exclusivity: at most one of hit/miss/stray per cycle. perfect_pulse only with hit_pulse.

Test Plan:
1. Reset, block_h 720→120 then +1/cycle, key edge at block_h=620 -> hit_pulse + perfect_pulse one cycle later; score=2, combo=1, judge_state=2.
2. Same ramp, key edge at block_h=570 -> hit only; score=1, combo=1. A second edge at block_h=600 -> stray_pulse, combo=0, score stays 1.
3. No key, ramp passes 680→681 -> miss_pulse on the 681 sample; combo=0; judge_state returns to 0 when block_h reaches 720.
4. Block at 300 in ACTIVE, block_h jumps to 120 (respawn) -> miss_pulse, judge_state stays 1. Key edge coincident with the respawn -> judged as stray (no extra miss).
5. stop_or_endgame=1 while block_h=650 and key rises -> no pulses, counters held. Release freeze with key still high -> no hit. A new edge afterwards while in window -> hit.
6. Preload score to 998 via repeated perfects, then a perfect -> score=999. A further perfect holds 999. 130 consecutive hits -> combo and max_combo=127. Mid-game restart -> all counters 0, judge_state 0.

Source files
------------

// File: rtl/lane_hit_judge.sv
// lane_hit_judge: judges each block of one falling-block lane as perfect, hit
// or miss against the player's key, flags stray presses, and keeps the lane's
// score, combo and max combo.
//
// Ports:
//   clk, rst_n       lane clock, asynchronous active-low reset
//   restart          synchronous clear to the reset state
//   stop_or_endgame  freeze: keys ignored, state and counters held
//   key              lane key level (synchronized upstream)
//   block_h[9:0]     lane block vertical position
//   hit_pulse        one-cycle pulse on a hit (also raised for a perfect)
//   perfect_pulse    one-cycle pulse on a hit inside the perfect window
//   miss_pulse       one-cycle pulse when a block is lost
//   stray_pulse      one-cycle pulse on a press with nothing judgeable
//   score[9:0]       saturating point total
//   combo[6:0]       saturating consecutive-hit count
//   max_combo[6:0]   highest combo since reset/restart
//   judge_state[1:0] 0 IDLE, 1 ACTIVE, 2 JUDGED
module lane_hit_judge #(
    parameter int unsigned JUDGE_LO  = 560,
    parameter int unsigned JUDGE_HI  = 680,
    parameter int unsigned PERF_LO   = 600,
    parameter int unsigned PERF_HI   = 640,
    parameter int unsigned BOTTOM    = 720,
    parameter int unsigned HIT_PTS   = 1,
    parameter int unsigned PERF_PTS  = 2,
    parameter int unsigned SCORE_MAX = 999
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       restart,
    input  logic       stop_or_endgame,
    input  logic       key,
    input  logic [9:0] block_h,
    output logic       hit_pulse,
    output logic       perfect_pulse,
    output logic       miss_pulse,
    output logic       stray_pulse,
    output logic [9:0] score,
    output logic [6:0] combo,
    output logic [6:0] max_combo,
    output logic [1:0] judge_state
);

    localparam int unsigned H_W     = 10;
    localparam int unsigned SUM_W   = H_W + 1;
    localparam int unsigned COMBO_W = 7;

    localparam logic [H_W-1:0]     L_JUDGE_LO = H_W'(JUDGE_LO);
    localparam logic [H_W-1:0]     L_JUDGE_HI = H_W'(JUDGE_HI);
    localparam logic [H_W-1:0]     L_PERF_LO  = H_W'(PERF_LO);
    localparam logic [H_W-1:0]     L_PERF_HI  = H_W'(PERF_HI);
    localparam logic [H_W-1:0]     L_BOTTOM   = H_W'(BOTTOM);
    localparam logic [COMBO_W-1:0] L_COMBO_MX = {COMBO_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_JUDGED = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_key_prev;
    logic [H_W-1:0]     r_prev_h;
    logic               r_hit;
    logic               r_perfect;
    logic               r_miss;
    logic               r_stray;
    logic [H_W-1:0]     r_score;
    logic [COMBO_W-1:0] r_combo;
    logic [COMBO_W-1:0] r_max_combo;

    logic               w_key_edge;
    logic               w_respawn;
    logic               w_in_win;
    logic               w_in_perf;
    logic               w_above;
    logic               w_hit;
    logic               w_miss;
    logic               w_stray;
    state_t             w_next;
    logic [SUM_W-1:0]   w_pts;
    logic [SUM_W-1:0]   w_sum;
    logic [H_W-1:0]     w_score_next;
    logic [COMBO_W-1:0] w_combo_inc;

    assign w_key_edge = key & ~r_key_prev;
    assign w_respawn  = (block_h < r_prev_h);
    assign w_in_win   = (block_h >= L_JUDGE_LO) && (block_h <= L_JUDGE_HI);
    assign w_in_perf  = (block_h >= L_PERF_LO) && (block_h <= L_PERF_HI);
    assign w_above    = (block_h > L_JUDGE_HI);

    // Saturating score and combo candidates for a hit this cycle
    assign w_pts        = w_in_perf ? SUM_W'(PERF_PTS) : SUM_W'(HIT_PTS);
    assign w_sum        = {1'b0, r_score} + w_pts;
    assign w_score_next = (w_sum > SUM_W'(SCORE_MAX)) ? H_W'(SCORE_MAX) : w_sum[H_W-1:0];
    assign w_combo_inc  = (r_combo == L_COMBO_MX) ? L_COMBO_MX : r_combo + COMBO_W'(1);

    // Judgement decode: which event fires and where the FSM goes
    always_comb begin
        w_hit   = 1'b0;
        w_miss  = 1'b0;
        w_stray = 1'b0;
        w_next  = r_state;
        if (w_respawn && w_key_edge) begin
            // Key lands on the freshly spawned block; it replaces any miss of
            // the abandoned one so only one event is reported.
            if (w_in_win) begin
                w_hit  = 1'b1;
                w_next = ST_JUDGED;
            end else if (w_above) begin
                w_miss = 1'b1;
                w_next = ST_JUDGED;
            end else begin
                w_stray = 1'b1;
                w_next  = ST_ACTIVE;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_respawn)       w_next  = ST_ACTIVE;
                    else if (w_key_edge) w_stray = 1'b1;
                end
                ST_ACTIVE: begin
                    if (w_respawn) begin
                        w_miss = 1'b1;
                    end else if (w_key_edge && w_in_win) begin
                        w_hit  = 1'b1;
                        w_next = ST_JUDGED;
                    end else if (w_above) begin
                        w_miss = 1'b1;
                        w_next = ST_JUDGED;
                    end else if (w_key_edge) begin
                        w_stray = 1'b1;
                    end
                end
                ST_JUDGED: begin
                    if (w_respawn)                 w_next  = ST_ACTIVE;
                    else if (block_h == L_BOTTOM)  w_next  = ST_IDLE;
                    else if (w_key_edge)           w_stray = 1'b1;
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // State, history, pulses and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_key_prev  <= 1'b0;
            r_prev_h    <= L_BOTTOM;
            r_hit       <= 1'b0;
            r_perfect   <= 1'b0;
            r_miss      <= 1'b0;
            r_stray     <= 1'b0;
            r_score     <= '0;
            r_combo     <= '0;
            r_max_combo <= '0;
        end else if (restart) begin
            r_state     <= ST_IDLE;
            r_key_prev  <= 1'b0;
            r_prev_h    <= L_BOTTOM;
            r_hit       <= 1'b0;
            r_perfect   <= 1'b0;
            r_miss      <= 1'b0;
            r_stray     <= 1'b0;
            r_score     <= '0;
            r_combo     <= '0;
            r_max_combo <= '0;
        end else begin
            r_hit     <= 1'b0;
            r_perfect <= 1'b0;
            r_miss    <= 1'b0;
            r_stray   <= 1'b0;
            if (!stop_or_endgame) begin
                r_key_prev <= key;
                r_prev_h   <= block_h;
                r_state    <= w_next;
                r_hit      <= w_hit;
                r_perfect  <= w_hit & w_in_perf;
                r_miss     <= w_miss;
                r_stray    <= w_stray;
                if (w_hit) begin
                    r_score <= w_score_next;
                    r_combo <= w_combo_inc;
                    if (w_combo_inc > r_max_combo) r_max_combo <= w_combo_inc;
                end else if (w_miss || w_stray) begin
                    r_combo <= '0;
                end
            end
        end
    end

    assign hit_pulse     = r_hit;
    assign perfect_pulse = r_perfect;
    assign miss_pulse    = r_miss;
    assign stray_pulse   = r_stray;
    assign score         = r_score;
    assign combo         = r_combo;
    assign max_combo     = r_max_combo;
    assign judge_state   = r_state;

endmodule

// File: tb/tb_lane_hit_judge.sv
// Testbench for lane_hit_judge: directed scenarios plus randomized lane
// traffic, all compared against a behavioural model of the lane rules.
module tb_lane_hit_judge;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       restart;
    logic       stop_or_endgame;
    logic       key;
    logic [9:0] block_h;
    logic       hit_pulse;
    logic       perfect_pulse;
    logic       miss_pulse;
    logic       stray_pulse;
    logic [9:0] score;
    logic [6:0] combo;
    logic [6:0] max_combo;
    logic [1:0] judge_state;

    lane_hit_judge dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .restart         (restart),
        .stop_or_endgame (stop_or_endgame),
        .key             (key),
        .block_h         (block_h),
        .hit_pulse       (hit_pulse),
        .perfect_pulse   (perfect_pulse),
        .miss_pulse      (miss_pulse),
        .stray_pulse     (stray_pulse),
        .score           (score),
        .combo           (combo),
        .max_combo       (max_combo),
        .judge_state     (judge_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: a lane holds at most one block; it is either awaiting judgement
    // (pending) or already judged and still falling (shown).
    bit m_pending;
    bit m_shown;
    int m_score, m_combo, m_max;
    int m_prev_h;
    bit m_key_prev;
    bit m_hit, m_perf, m_miss, m_stray;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_pending = 0; m_shown = 0;
        m_score = 0; m_combo = 0; m_max = 0;
        m_prev_h = 720; m_key_prev = 0;
        m_hit = 0; m_perf = 0; m_miss = 0; m_stray = 0;
    endtask

    task automatic model_event_hit(input bit perfect);
        m_hit = 1;
        m_perf = perfect;
        m_score = m_score + (perfect ? 2 : 1);
        if (m_score > 999) m_score = 999;
        m_combo = (m_combo >= 127) ? 127 : m_combo + 1;
        if (m_combo > m_max) m_max = m_combo;
        m_pending = 0; m_shown = 1;
    endtask

    task automatic model_event_loss(input bit is_miss);
        if (is_miss) m_miss = 1; else m_stray = 1;
        m_combo = 0;
    endtask

    // Judge the pending block against the current height with a key press
    task automatic model_judge_press(input int h);
        if (h >= 560 && h <= 680) model_event_hit(h >= 600 && h <= 640);
        else if (h > 680) begin model_event_loss(1); m_pending = 0; m_shown = 1; end
        else model_event_loss(0);
    endtask

    task automatic model_step();
        int h;
        bit press, respawn, lost;
        m_hit = 0; m_perf = 0; m_miss = 0; m_stray = 0;
        if (restart) begin model_clear(); return; end
        if (stop_or_endgame) return;
        h = int'(block_h);
        press = key && !m_key_prev;
        respawn = h < m_prev_h;
        m_key_prev = key;
        m_prev_h = h;
        if (respawn) begin
            lost = m_pending;
            m_pending = 1; m_shown = 0;
            if (press) model_judge_press(h);
            else if (lost) model_event_loss(1);
        end else if (m_pending) begin
            if (press && h >= 560 && h <= 680) model_judge_press(h);
            else if (h > 680) model_judge_press(h);
            else if (press) model_event_loss(0);
        end else if (m_shown) begin
            if (h == 720) m_shown = 0;
            else if (press) model_event_loss(0);
        end else if (press) begin
            model_event_loss(0);
        end
    endtask

    function automatic int model_state();
        return m_pending ? 1 : (m_shown ? 2 : 0);
    endfunction

    task automatic check_all();
        check("hit_pulse",     int'(hit_pulse),     int'(m_hit));
        check("perfect_pulse", int'(perfect_pulse), int'(m_perf));
        check("miss_pulse",    int'(miss_pulse),    int'(m_miss));
        check("stray_pulse",   int'(stray_pulse),   int'(m_stray));
        check("score",         int'(score),         m_score);
        check("combo",         int'(combo),         m_combo);
        check("max_combo",     int'(max_combo),     m_max);
        check("judge_state",   int'(judge_state),   model_state());
    endtask

    // One clock: apply inputs, advance the model, sample after the edge
    task automatic cyc(input int bh, input bit k);
        block_h = 10'(bh);
        key = k;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic ramp(input int from, input int to, input int k1, input int k2);
        for (int h = from; h <= to; h++) cyc(h, (h == k1) || (h == k2));
    endtask

    task automatic do_restart();
        restart = 1'b1;
        cyc(720, 0);
        restart = 1'b0;
        check("restart_score", int'(score), 0);
        check("restart_state", int'(judge_state), 0);
    endtask

    initial begin
        int cur, h, r;
        rst_n = 1'b0; restart = 1'b0; stop_or_endgame = 1'b0;
        key = 1'b0; block_h = 10'd720;
        model_clear();
        #12;
        check_all();
        check("reset_combo", int'(combo), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: perfect hit at 620
        cyc(720, 0);
        ramp(120, 619, -1, -1);
        cyc(620, 1);
        check("t1_hit", int'(hit_pulse), 1);
        check("t1_perfect", int'(perfect_pulse), 1);
        check("t1_score", int'(score), 2);
        check("t1_combo", int'(combo), 1);
        check("t1_state", int'(judge_state), 2);
        ramp(621, 720, -1, -1);
        check("t1_idle", int'(judge_state), 0);

        // 2: plain hit at 570, then stray at 600
        do_restart();
        ramp(120, 569, -1, -1);
        cyc(570, 1);
        check("t2_hit", int'(hit_pulse), 1);
        check("t2_noperf", int'(perfect_pulse), 0);
        check("t2_score", int'(score), 1);
        ramp(571, 599, -1, -1);
        cyc(600, 1);
        check("t2_stray", int'(stray_pulse), 1);
        check("t2_combo", int'(combo), 0);
        check("t2_score_held", int'(score), 1);
        ramp(601, 720, -1, -1);

        // 3: unpressed block falls out of the window
        do_restart();
        ramp(120, 680, -1, -1);
        check("t3_no_early_miss", int'(miss_pulse), 0);
        cyc(681, 0);
        check("t3_miss", int'(miss_pulse), 1);
        check("t3_state", int'(judge_state), 2);
        ramp(682, 719, -1, -1);
        check("t3_still_judged", int'(judge_state), 2);
        cyc(720, 0);
        check("t3_idle", int'(judge_state), 0);

        // 4: respawn abandons a block; press coincident with respawn
        do_restart();
        ramp(120, 300, -1, -1);
        cyc(120, 0);
        check("t4_miss", int'(miss_pulse), 1);
        check("t4_state", int'(judge_state), 1);
        ramp(121, 300, -1, -1);
        cyc(120, 1);
        check("t4_stray", int'(stray_pulse), 1);
        check("t4_no_miss", int'(miss_pulse), 0);
        check("t4_state2", int'(judge_state), 1);
        ramp(121, 720, -1, -1);

        // 5: freeze holds everything; held key across unfreeze is no edge
        do_restart();
        ramp(120, 539, -1, -1);
        for (int hh = 540; hh <= 649; hh++) cyc(hh, 1);
        stop_or_endgame = 1'b1;
        cyc(650, 0);
        cyc(651, 1);
        check("t5_frozen_hit", int'(hit_pulse), 0);
        check("t5_frozen_state", int'(judge_state), 1);
        stop_or_endgame = 1'b0;
        cyc(652, 1);
        check("t5_no_hit", int'(hit_pulse), 0);
        cyc(653, 0);
        cyc(654, 1);
        check("t5_hit", int'(hit_pulse), 1);
        check("t5_score", int'(score), 1);
        ramp(655, 720, -1, -1);

        // 6: saturation of score and combo, then mid-game restart
        do_restart();
        for (int i = 0; i < 499; i++) begin
            cyc(120, 0);
            cyc(620, 1);
            if (i == 129) begin
                check("t6_combo130", int'(combo), 127);
                check("t6_max130", int'(max_combo), 127);
            end
        end
        check("t6_score998", int'(score), 998);
        cyc(120, 0);
        cyc(620, 1);
        check("t6_score999", int'(score), 999);
        cyc(120, 0);
        cyc(620, 1);
        check("t6_perf_sat", int'(perfect_pulse), 1);
        check("t6_score_sat", int'(score), 999);
        cyc(120, 0);
        cyc(200, 0);
        cyc(201, 1);
        check("t6_stray_combo", int'(combo), 0);
        check("t6_max_kept", int'(max_combo), 127);
        cyc(300, 0);
        restart = 1'b1;
        cyc(310, 0);
        restart = 1'b0;
        check("t6_rs_score", int'(score), 0);
        check("t6_rs_max", int'(max_combo), 0);
        check("t6_rs_state", int'(judge_state), 0);

        // Randomized lane traffic
        cur = 720;
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3 || (cur == 720 && r < 20)) h = int'($urandom_range(100, 400));
            else if (r == 3) h = int'($urandom_range(500, 720));
            else begin
                h = cur + int'($urandom_range(0, 4));
                if (h > 720) h = 720;
            end
            cur = h;
            stop_or_endgame = ($urandom_range(0, 39) == 0);
            restart = ($urandom_range(0, 499) == 0);
            cyc(h, $urandom_range(0, 9) < 3);
        end
        restart = 1'b0;
        stop_or_endgame = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
